key_debounce_bank: RTL and testbench

//  Multi-channel key debouncer for the keyboard front end. It sits between the raw
//  key/button pins and the note logic. Each channel is synchronised and then sampled
//  on a shared prescaled tick. A channel's debounced level changes only after DEPTH

---
 rtl/key_debounce_bank_pkg.sv | 15 +
 rtl/debounce_channel.sv | 54 +++++
 rtl/key_debounce_bank.sv | 87 ++++++++
 tb/tb_key_debounce_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_bank_pkg.sv
// Board-level defaults and width helpers shared by the key debounce bank.
package key_debounce_bank_pkg;

  localparam int unsigned BOARD_CLK_HZ           = 100_000_000;
  localparam int unsigned SAMPLE_HZ              = 1_000;
  localparam int unsigned BOARD_TICK_DIV         = BOARD_CLK_HZ / SAMPLE_HZ;
  localparam int unsigned DEFAULT_DEBOUNCE_DEPTH = 8;
  localparam int unsigned KEY_ACTIVE_LOW         = 0;

  // Width of an index/counter field: $clog2(n) forced odd, never below 1.
  function automatic int unsigned width_min1(input int unsigned n);
    return 32'($clog2(n)) | 32'd1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key channel: 2-flop synchroniser, tick-sampled history, debounced level and edge pulses.
module debounce_channel #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic tick_i,
  output logic db_o,
  output logic press_o,
  output logic release_o
);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] sh_q;
  logic             db_q;
  logic             press_q;
  logic             release_q;
  logic             all_ones_c;
  logic             all_zeros_c;

  assign all_ones_c  = &sh_q;
  assign all_zeros_c = ~|sh_q;

  // Newest sample enters at the MSB; level flips only on a full window of agreement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      sh_q      <= '0;
      db_q      <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (tick_i) begin
        sh_q <= {sync_q[1], sh_q[DEPTH-1:1]};
      end
      if (all_ones_c && !db_q) begin
        db_q    <= 1'b1;
        press_q <= 1'b1;
      end else if (all_zeros_c && db_q) begin
        db_q      <= 1'b0;
        release_q <= 1'b1;
      end
    end
  end

  assign db_o      = db_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce_bank.sv
// Multi-channel key debouncer: shared sample prescaler, per-key channels and a
// lowest-index pressed-key encoder.
module key_debounce_bank
  import key_debounce_bank_pkg::*;
#(
  parameter int unsigned N_KEYS     = 8,
  parameter int unsigned DEPTH      = DEFAULT_DEBOUNCE_DEPTH,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned ACTIVE_LOW = KEY_ACTIVE_LOW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_KEYS-1:0]             keys_raw,
  output logic [N_KEYS-1:0]             keys_db,
  output logic [N_KEYS-1:0]             press_pulse,
  output logic [N_KEYS-1:0]             release_pulse,
  output logic [width_min1(N_KEYS)-1:0] key_code,
  output logic                          key_valid
);

  localparam int unsigned CNT_W = width_min1(TICK_DIV);
  localparam int unsigned KCW   = width_min1(N_KEYS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              tick_c;
  logic [N_KEYS-1:0] keys_in_c;
  logic [N_KEYS-1:0] db_c;
  logic [KCW-1:0]    key_code_q;
  logic [KCW-1:0]    key_code_d;
  logic              key_valid_q;

  // Shared sample prescaler; with TICK_DIV==1 the counter sits at 0 and ticks every cycle.
  assign tick_c = (cnt_q == CNT_MAX);
  assign cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign keys_in_c = (ACTIVE_LOW != 0) ? ~keys_raw : keys_raw;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    debounce_channel #(
      .DEPTH(DEPTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .key_i    (keys_in_c[g]),
      .tick_i   (tick_c),
      .db_o     (db_c[g]),
      .press_o  (press_pulse[g]),
      .release_o(release_pulse[g])
    );
  end

  assign keys_db = db_c;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    key_code_d = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (db_c[i]) begin
        key_code_d = KCW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= |db_c;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Bench for key_debounce_bank: three configurations checked every cycle against a
// run-length model, plus directed literal expectations for each scenario.
module tb_key_debounce_bank;

  localparam int DEP [3] = '{4, 3, 4};
  localparam int DIV [3] = '{1, 5, 1};
  localparam bit AL  [3] = '{1'b0, 1'b0, 1'b1};

  logic       clk;
  logic       rst;
  logic [3:0] raw    [3];
  logic [3:0] db_o   [3];
  logic [3:0] pr_o   [3];
  logic [3:0] rl_o   [3];
  logic [2:0] code_o [3];
  logic       valid_o[3];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  key_debounce_bank #(.N_KEYS(4), .DEPTH(4), .TICK_DIV(1), .ACTIVE_LOW(0)) u_dut0 (
    .clk(clk), .rst(rst), .keys_raw(raw[0]), .keys_db(db_o[0]), .press_pulse(pr_o[0]),
    .release_pulse(rl_o[0]), .key_code(code_o[0]), .key_valid(valid_o[0]));

  key_debounce_bank #(.N_KEYS(4), .DEPTH(3), .TICK_DIV(5), .ACTIVE_LOW(0)) u_dut1 (
    .clk(clk), .rst(rst), .keys_raw(raw[1]), .keys_db(db_o[1]), .press_pulse(pr_o[1]),
    .release_pulse(rl_o[1]), .key_code(code_o[1]), .key_valid(valid_o[1]));

  key_debounce_bank #(.N_KEYS(4), .DEPTH(4), .TICK_DIV(1), .ACTIVE_LOW(1)) u_dut2 (
    .clk(clk), .rst(rst), .keys_raw(raw[2]), .keys_db(db_o[2]), .press_pulse(pr_o[2]),
    .release_pulse(rl_o[2]), .key_code(code_o[2]), .key_valid(valid_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic lit(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pins are seen two edges late; a channel adopts a level once the last
  // DEPTH tick samples all agree on it (tracked as a run of equal samples).
  int       m_cnt [3];
  bit [3:0] m_s1  [3];
  bit [3:0] m_s2  [3];
  bit [3:0] m_runv[3];
  int       m_runl[3][4];
  bit [3:0] m_db  [3];
  bit [3:0] m_pr  [3];
  bit [3:0] m_rl  [3];
  bit [2:0] m_code[3];
  bit       m_valid[3];

  always @(posedge clk) begin : model
    bit tk;
    for (int u = 0; u < 3; u++) begin
      if (!rst) begin
        m_cnt[u] = 0; m_s1[u] = '0; m_s2[u] = '0; m_runv[u] = '0;
        m_db[u] = '0; m_pr[u] = '0; m_rl[u] = '0; m_code[u] = '0; m_valid[u] = 1'b0;
        for (int c = 0; c < 4; c++) m_runl[u][c] = DEP[u];
      end else begin
        tk = (m_cnt[u] == DIV[u] - 1);
        m_cnt[u] = tk ? 0 : m_cnt[u] + 1;
        m_valid[u] = |m_db[u];
        m_code[u] = '0;
        for (int c = 3; c >= 0; c--) if (m_db[u][c]) m_code[u] = 3'(c);
        for (int c = 0; c < 4; c++) begin
          m_pr[u][c] = 1'b0;
          m_rl[u][c] = 1'b0;
          if (m_runl[u][c] >= DEP[u] && m_runv[u][c] != m_db[u][c]) begin
            m_db[u][c] = m_runv[u][c];
            m_pr[u][c] = m_runv[u][c];
            m_rl[u][c] = ~m_runv[u][c];
          end
          if (tk) begin
            if (m_s2[u][c] == m_runv[u][c]) m_runl[u][c]++;
            else begin
              m_runv[u][c] = m_s2[u][c];
              m_runl[u][c] = 1;
            end
          end
          m_s2[u][c] = m_s1[u][c];
          m_s1[u][c] = raw[u][c] ^ AL[u];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      for (int u = 0; u < 3; u++) begin
        lit($sformatf("u%0d_db", u),    int'(db_o[u]),    int'(m_db[u]));
        lit($sformatf("u%0d_press", u), int'(pr_o[u]),    int'(m_pr[u]));
        lit($sformatf("u%0d_rel", u),   int'(rl_o[u]),    int'(m_rl[u]));
        lit($sformatf("u%0d_code", u),  int'(code_o[u]),  int'(m_code[u]));
        lit($sformatf("u%0d_valid", u), int'(valid_o[u]), int'(m_valid[u]));
      end
      lit("u1_cnt",  int'(u_dut1.cnt_q),  m_cnt[1]);
      lit("u1_tick", int'(u_dut1.tick_c), int'(m_cnt[1] == DIV[1] - 1));
    end
  end

  initial begin
    int hits;
    int ticks;
    int maxc;
    rst = 1'b0;
    raw[0] = 4'h0; raw[1] = 4'h0; raw[2] = 4'hF;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    lit("reset_db",    int'(db_o[0]),    0);
    lit("reset_valid", int'(valid_o[0]), 0);
    lit("reset_code",  int'(code_o[0]),  0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    lit("al_idle_no_press", int'(db_o[2]), 0);

    // Clean press and release on channel 0, DEPTH=4, every-cycle sampling.
    raw[0][0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) lit("t1_db_early", int'(db_o[0][0]), 0);
    end
    lit("t1_db_rise", int'(db_o[0][0]), 1);
    lit("t1_press",   int'(pr_o[0][0]), 1);
    @(negedge clk);
    lit("t1_press_width", int'(pr_o[0][0]), 0);
    raw[0][0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) lit("t1_rel_early", int'(db_o[0][0]), 1);
    end
    lit("t1_db_fall", int'(db_o[0][0]), 0);
    lit("t1_release", int'(rl_o[0][0]), 1);
    @(negedge clk);
    lit("t1_release_width", int'(rl_o[0][0]), 0);

    // Bounce on channel 1 never completes a window.
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      raw[0][1] = (k % 2 == 0);
      @(negedge clk);
      hits += int'(pr_o[0][1] | rl_o[0][1] | db_o[0][1]);
    end
    raw[0][1] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      hits += int'(pr_o[0][1] | rl_o[0][1] | db_o[0][1]);
    end
    lit("t2_bounce_quiet", hits, 0);

    // Lowest-index encoder follows keys_db one cycle later.
    raw[0] = 4'b1010;
    repeat (7) @(negedge clk);
    lit("t4_db_31",       int'(db_o[0]),    4'b1010);
    lit("t4_valid_lag",   int'(valid_o[0]), 0);
    @(negedge clk);
    lit("t4_code_1",      int'(code_o[0]),  1);
    lit("t4_valid_1",     int'(valid_o[0]), 1);
    raw[0] = 4'b1000;
    repeat (7) @(negedge clk);
    lit("t4_db_3",        int'(db_o[0]),    4'b1000);
    lit("t4_code_lag",    int'(code_o[0]),  1);
    @(negedge clk);
    lit("t4_code_3",      int'(code_o[0]),  3);
    raw[0] = 4'b0000;
    repeat (7) @(negedge clk);
    lit("t4_db_none",     int'(db_o[0]),    0);
    lit("t4_valid_hold",  int'(valid_o[0]), 1);
    @(negedge clk);
    lit("t4_valid_0",     int'(valid_o[0]), 0);
    lit("t4_code_0",      int'(code_o[0]),  0);

    // Reset while channel 0 is pressed and channel 2 is half-filled.
    raw[0] = 4'b0001;
    repeat (8) @(negedge clk);
    lit("t5_db0_set", int'(db_o[0][0]), 1);
    raw[0][2] = 1'b1;
    repeat (4) @(negedge clk);
    lit("t5_ch2_pending", int'(db_o[0][2]), 0);
    rst = 1'b0;
    @(negedge clk);
    lit("t5_rst_db",    int'(db_o[0]),    0);
    lit("t5_rst_rel",   int'(rl_o[0]),    0);
    lit("t5_rst_valid", int'(valid_o[0]), 0);
    rst = 1'b1;
    raw[1] = 4'b0100;

    // Re-press after reset on u0 alongside the prescaled channel on u1.
    ticks = 0;
    maxc  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ticks += int'(u_dut1.tick_c);
      if (int'(u_dut1.cnt_q) > maxc) maxc = int'(u_dut1.cnt_q);
      if (k == 6)  lit("t5_repress_early", int'(db_o[0]), 0);
      if (k == 7) begin
        lit("t5_repress_db",    int'(db_o[0]), 4'b0101);
        lit("t5_repress_press", int'(pr_o[0]), 4'b0101);
      end
      if (k == 15) lit("t3_db_early", int'(db_o[1][2]), 0);
      if (k == 16) begin
        lit("t3_db_rise", int'(db_o[1][2]), 1);
        lit("t3_press",   int'(pr_o[1][2]), 1);
      end
    end
    lit("t3_tick_count", ticks, 4);
    lit("t3_cnt_max",    maxc,  4);

    // Active-low pin: driving 0 is a press.
    raw[2][0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) lit("t6_db_early", int'(db_o[2][0]), 0);
    end
    lit("t6_db_rise", int'(db_o[2][0]), 1);
    lit("t6_press",   int'(pr_o[2][0]), 1);
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
